// File: rtl/sram_seq_pkg.sv
// Shared types and default constants for the SRAM access sequencer.
// Owner encoding doubles as the arbiter's last-grant register value.
package sram_seq_pkg;

  localparam int unsigned ADDR_W_DEF  = 20;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Wait counter runs 0..max(rd,wr)-1, so it needs clog2(max) bits, at least one.
  function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
    int unsigned m;
    m = (rd > wr) ? rd : wr;
    return (m <= 32'd1) ? 32'd1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_access_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win last time is chosen.
// last_grant only moves when the sequencer actually accepts the grant (update strobe).
module rr_arbiter2
  import sram_seq_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  logic   update,
  output logic   grant_valid,
  output owner_e grant_owner
);

  owner_e last_grant_q, last_grant_d;

  // Grant selection and last-grant update
  always_comb begin
    grant_valid  = req_cpu | req_dbg;
    last_grant_d = last_grant_q;
    if (req_cpu && req_dbg) begin
      grant_owner = (last_grant_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (req_cpu) begin
      grant_owner = OWN_CPU;
    end else begin
      grant_owner = OWN_DBG;
    end
    if (update && grant_valid) begin
      last_grant_d = grant_owner;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; DBG after reset so the CPU wins the first tie
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= OWN_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_access_sequencer.sv
// Owns the shared asynchronous SRAM: arbitrates CPU vs debug requests and turns each
// single-word access into a registered CE/OE/WE strobe sequence with fixed wait states.
module sram_access_sequencer
  import sram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_WAIT);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              bytes_n_q, bytes_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_done_q, dbg_done_d;

  logic              grant_valid;
  owner_e            grant_owner;
  logic              grant_upd;
  logic              access_last;
  logic              bus_active;

  rr_arbiter2 u_arb (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_cpu     (cpu_req),
    .req_dbg     (dbg_req),
    .update      (grant_upd),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state logic and request latching; requests are only looked at in IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_upd   = 1'b0;
    access_last = (cnt_q == (we_q ? WR_LAST : RD_LAST));
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_upd = 1'b1;
          owner_d   = grant_owner;
          cnt_d     = '0;
          if (grant_owner == OWN_CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end
          state_d = we_d ? ST_WR_SETUP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (access_last) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = ST_WR_HOLD;
          end else begin
            state_d = ST_DONE;
            if (owner_q == OWN_CPU) begin
              cpu_rdata_d = sram_dq_in;
            end else begin
              dbg_rdata_d = sram_dq_in;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes decoded from the next state so the pins come straight off flops
  always_comb begin
    bus_active = (state_d == ST_WR_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_WR_HOLD);
    ce_n_d     = ~bus_active;
    bytes_n_d  = ~bus_active;
    oe_n_d     = ~((state_d == ST_ACCESS) && !we_d);
    we_n_d     = ~((state_d == ST_ACCESS) && we_d);
    dq_oe_d    = bus_active && we_d;
    cpu_done_d = (state_d == ST_DONE) && (owner_d == OWN_CPU);
    dbg_done_d = (state_d == ST_DONE) && (owner_d == OWN_DBG);
  end

  // State, datapath and output registers; reset aborts any access in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bytes_n_q   <= 1'b1;
      dq_oe_q     <= 1'b0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bytes_n_q   <= bytes_n_d;
      dq_oe_q     <= dq_oe_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign cpu_done    = cpu_done_q;
  assign dbg_done    = dbg_done_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = bytes_n_q;
  assign sram_lb_n   = bytes_n_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed scoreboard bench for sram_access_sequencer: expected completions are queued
// when requests are driven and checked against each done pulse.
module tb_sram_access_sequencer;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int RDW = 2;
  localparam int WRW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, sram_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic [DW-1:0] sram_dq_out, sram_dq_in;
  logic          cpu_done, dbg_done, sram_dq_oe;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  typedef struct {
    bit            own;   // 0 = CPU, 1 = DBG
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;  // read: expected rdata, write: expected bus data
    int            lat;
  } item_t;

  item_t         sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] cpu_rd_m = '0;
  logic [DW-1:0] dbg_rd_m = '0;

  sram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit own, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input int lat);
    item_t it;
    it.own = own; it.we = we; it.addr = addr; it.data = data; it.lat = lat;
    sb.push_back(it);
  endtask

  // Wait (bounded) for the next done pulse, checking bus rules every cycle, then
  // pop the scoreboard and also check that done lasts exactly one cycle.
  task automatic wait_done(input int budget, input bit drop, input string tag);
    int            cyc, oe_c, we_c;
    bit            seen;
    item_t         it;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    cyc = 0; oe_c = 0; we_c = 0; seen = 1'b0; wa = '0; wd = '0;
    while (!seen && cyc < budget) begin
      @(negedge Clk);
      cyc++;
      check({tag, "/oe_we_excl"}, {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
      check({tag, "/oe_dq_excl"}, {31'd0, (!sram_oe_n && sram_dq_oe)}, 32'd0);
      if (!sram_ce_n) check({tag, "/bytes"}, {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) begin
        we_c++; wa = sram_addr; wd = sram_dq_out;
      end
      if (cpu_done || dbg_done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check({tag, "/unexpected_done"}, sb.size(), 32'd1);
        end else begin
          it = sb.pop_front();
          check({tag, "/owner"}, {30'd0, cpu_done, dbg_done}, it.own ? 32'd1 : 32'd2);
          check({tag, "/latency"}, cyc, it.lat);
          check({tag, "/addr"}, sram_addr, it.addr);
          if (it.we) begin
            check({tag, "/we_cycles"}, we_c, WRW);
            check({tag, "/oe_cycles"}, oe_c, 32'd0);
            check({tag, "/wr_addr"}, wa, it.addr);
            check({tag, "/wr_data"}, wd, it.data);
          end else begin
            check({tag, "/oe_cycles"}, oe_c, RDW);
            check({tag, "/we_cycles"}, we_c, 32'd0);
            if (it.own) dbg_rd_m = it.data; else cpu_rd_m = it.data;
          end
          check({tag, "/cpu_rdata"}, cpu_rdata, cpu_rd_m);
          check({tag, "/dbg_rdata"}, dbg_rdata, dbg_rd_m);
        end
        if (drop) begin
          if (cpu_done) cpu_req = 1'b0;
          if (dbg_done) dbg_req = 1'b0;
        end
      end
    end
    if (!seen) begin
      check({tag, "/done_seen"}, {31'd0, seen}, 32'd1);
    end else begin
      @(negedge Clk);
      check({tag, "/done_one_cycle"}, {30'd0, cpu_done, dbg_done}, 32'd0);
    end
  endtask

  initial begin
    bit hit;
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    sram_dq_in = '0;
    repeat (2) @(negedge Clk);
    check("reset/strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    check("reset/dq_oe_done", {29'd0, sram_dq_oe, cpu_done, dbg_done}, 32'd0);
    check("reset/addr", sram_addr, 32'd0);
    check("reset/dq_out", sram_dq_out, 32'd0);
    check("reset/rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // CPU read
    sram_dq_in = 16'hBEEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    push(1'b0, 1'b0, 20'h00010, 16'hBEEF, RDW + 1);
    wait_done(20, 1'b1, "cpu_rd");

    // DBG write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00020; dbg_wdata = 16'h1234;
    push(1'b1, 1'b1, 20'h00020, 16'h1234, WRW + 3);
    wait_done(20, 1'b1, "dbg_wr");

    // Simultaneous requests: CPU wins the first tie
    sram_dq_in = 16'hA5A5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00030;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h00040;
    push(1'b0, 1'b0, 20'h00030, 16'hA5A5, RDW + 1);
    push(1'b1, 1'b0, 20'h00040, 16'h5A5A, RDW + 1);
    wait_done(20, 1'b1, "tie_cpu");
    sram_dq_in = 16'h5A5A;
    wait_done(20, 1'b1, "tie_dbg");
    check("tie/no_extra", sb.size(), 32'd0);

    // Both held: grants alternate CPU, DBG, CPU, DBG
    sram_dq_in = 16'h7777;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00100; cpu_wdata = 16'hC0DE;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h00200;
    push(1'b0, 1'b1, 20'h00100, 16'hC0DE, WRW + 3);
    push(1'b1, 1'b0, 20'h00200, 16'h7777, RDW + 1);
    push(1'b0, 1'b1, 20'h00100, 16'hC0DE, WRW + 3);
    push(1'b1, 1'b0, 20'h00200, 16'h7777, RDW + 1);
    wait_done(20, 1'b0, "alt1_cpu");
    wait_done(20, 1'b0, "alt2_dbg");
    wait_done(20, 1'b1, "alt3_cpu");
    wait_done(20, 1'b1, "alt4_dbg");

    // Request dropped and address changed after the grant edge
    sram_dq_in = 16'h1357;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00050;
    push(1'b0, 1'b0, 20'h00050, 16'h1357, RDW + 1);
    @(posedge Clk);
    #1;
    cpu_req = 1'b0; cpu_addr = 20'h0FFFF;
    wait_done(20, 1'b1, "drop_req");

    // Reset during write ACCESS aborts the access
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00060; dbg_wdata = 16'hFACE;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge Clk);
      if (!sram_we_n) hit = 1'b1;
    end
    check("rst_mid/we_seen", {31'd0, hit}, 32'd1);
    Reset = 1'b1; dbg_req = 1'b0;
    @(negedge Clk);
    check("rst_mid/strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    check("rst_mid/dq_oe_done", {29'd0, sram_dq_oe, cpu_done, dbg_done}, 32'd0);
    Reset = 1'b0;
    cpu_rd_m = '0; dbg_rd_m = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("rst_mid/no_done", {30'd0, cpu_done, dbg_done}, 32'd0);
    end
    check("rst_mid/rdata", {cpu_rdata, dbg_rdata}, 32'd0);

    // Arbiter history cleared by reset: CPU wins the tie again
    sram_dq_in = 16'h2468;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00070;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00080; dbg_wdata = 16'h9ABC;
    push(1'b0, 1'b0, 20'h00070, 16'h2468, RDW + 1);
    push(1'b1, 1'b1, 20'h00080, 16'h9ABC, WRW + 3);
    wait_done(20, 1'b1, "post_rst_cpu");
    wait_done(20, 1'b1, "post_rst_dbg");
    check("end/sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
